wm8978_cfg_seq: RTL and testbench
=================================

Name: wm8978_cfg_seq

Overview:
Power-up configuration sequencer for the WM8978 codec. After a start-up delay it walks a fixed table of 16-bit register words {7-bit addr, 9-bit data} and issues each one to the existing I2C byte-pair driver through an exec/done handshake. It retries on NACK, then flags completion or error. The audio send/receive datapath is gated off by `cfg_done` until configuration finishes.

Parameters:
- STARTUP_CYCLES, 20'd1_000_000: clk cycles to wait after reset before the first write (codec power settle).
- REG_NUM, 5'd19: number of table entries to write, indices 0..REG_NUM-1.
- GAP_CYCLES, 10'd500: idle clk cycles between successive writes.
- MAX_RETRY, 2'd3: NACK retries per register before declaring an error.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: reset, asynchronous, active-high.
- i2c_exec, output, 1: one-cycle pulse that starts an I2C write.
- i2c_data, output, 16: {reg_addr[6:0], reg_data[8:0]}; held stable from the exec pulse until done.
- i2c_done, input, 1: one-cycle pulse from the driver when the transfer ends.
- i2c_ack_err, input, 1: sampled only in the i2c_done cycle; 1 = NACK.
- vol_req, input, 1: level request for a headphone volume update (feature only).
- vol_val, input, 6: headphone volume code 0..63 (feature only).
- vol_ack, output, 1: one-cycle pulse when the volume update completes (feature only).
- cfg_done, output, 1: high once all table writes succeed; sticky until reset.
- cfg_err, output, 1: high if any register exhausts its retries; sticky until reset.

Behaviour:
- Reset (async, rst=1) values:
  - i2c_exec=0, i2c_data=16'h0000, cfg_done=0, cfg_err=0, vol_ack=0.
  - state=WAIT_PWR; delay counter, index and retry counter all 0.
- States:
  - WAIT_PWR: count to STARTUP_CYCLES-1, then go to ISSUE.
  - ISSUE: drive i2c_data from the table at the current index; pulse i2c_exec for exactly one cycle; go to BUSY.
  - BUSY: hold i2c_data and wait for i2c_done.
    - Done with ack_err=0: index+1, clear retry, go to GAP.
    - Done with ack_err=1 and retry<MAX_RETRY: retry+1, go to GAP, then reissue the same index.
    - Done with ack_err=1 and retry==MAX_RETRY: go to ERR.
  - GAP: wait GAP_CYCLES. Go to DONE if index==REG_NUM, otherwise to ISSUE.
  - DONE: cfg_done=1. Accept volume requests when the feature is compiled in.
  - ERR: cfg_err=1 and cfg_done=0; terminal until reset.
- Latency: first i2c_exec occurs STARTUP_CYCLES+1 cycles after reset deassertion. A fault-free run takes REG_NUM×(2+T_i2c+GAP_CYCLES) cycles beyond that.
- i2c_done outside BUSY is ignored. An i2c_done in the same cycle as the exec pulse is ignored; BUSY begins the cycle after exec.
- Table is fixed:
  - Entry 0: R0 soft reset, 0x000.
  - Entries 1..: power management R1/R2/R3, I2S 32-bit format R4, slave-mode clocking R6, ADC/DAC and line-in routing, headphone volume R52/R53.
  - Index ≥ REG_NUM returns 16'h0000.
- Counters saturate at their terminal value; they never wrap. Index width is 5 bits, so REG_NUM ≤ 31.
- Asserting rst mid-transfer aborts immediately; the driver is expected to be reset by the same rst.

Optional Feature:
- Macro: WM8978_VOL_UPDATE_EN.
- Defined:
  - In DONE, vol_req=1 latches vol_val and writes R52 data {1'b0,2'b00,vol}, then R53 data {1'b1(HPVU),2'b00,vol}.
  - Both writes use the same ISSUE/BUSY/GAP/retry path.
  - vol_ack pulses one cycle after the R53 success, then the block returns to DONE.
  - vol_req still high at that point starts a new update with the current vol_val.
  - Exhausting retries goes to ERR and clears cfg_done.
- Undefined: vol_req and vol_val are ignored, vol_ack is tied to 0, and DONE is terminal.

Decomposition:
- Package wm8978_pkg:
  - Register address constants R_RESET=7'd0, R_PWR1=7'd1, R_PWR2=7'd2, R_PWR3=7'd3, R_AIF=7'd4, R_CLK=7'd6, R_LOUT1=7'd52, R_ROUT1=7'd53.
  - State encoding typedef.
  - Function that packs {addr, data} into 16 bits.
- Sub-module wm8978_reg_rom: combinational index→16-bit word lookup, holding the table.

Test Plan:
- Reset release, STARTUP_CYCLES=100, GAP=10, REG_NUM=19, driver model acks everything -> first exec at cycle 101; 19 exec pulses; i2c_data[15:9] sequence matches the table (first 16'h0000); cfg_done=1 after the last gap; cfg_err=0.
- Driver NACKs index 3 twice, then acks -> three exec pulses carrying identical i2c_data; the sequence continues to index 4; cfg_done=1.
- Driver always NACKs index 5, MAX_RETRY=3 -> exactly 4 exec pulses at index 5, then cfg_err=1; no further exec; cfg_done stays 0.
- Spurious i2c_done during WAIT_PWR and GAP -> no state change; the exec count is unchanged.
- WM8978_VOL_UPDATE_EN defined, in DONE, vol_req=1 with vol_val=6'd40 -> writes 16'h6828 then 16'h6B28; vol_ack pulses once.
- rst asserted during BUSY at index 7 -> all outputs return to reset values within the same cycle; after release the sequence restarts from index 0.

Source files
------------

// File: rtl/wm8978_pkg.sv
// ============================================================================
// Module : wm8978_pkg
// Brief  : Shared register addresses, sequencer state type and word packing
//          for the WM8978 configuration sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package wm8978_pkg;

  localparam logic [6:0] R_RESET = 7'd0;
  localparam logic [6:0] R_PWR1  = 7'd1;
  localparam logic [6:0] R_PWR2  = 7'd2;
  localparam logic [6:0] R_PWR3  = 7'd3;
  localparam logic [6:0] R_AIF   = 7'd4;
  localparam logic [6:0] R_CLK   = 7'd6;
  localparam logic [6:0] R_LOUT1 = 7'd52;
  localparam logic [6:0] R_ROUT1 = 7'd53;

  typedef enum logic [2:0] {
    ST_WAIT_PWR = 3'd0,
    ST_ISSUE    = 3'd1,
    ST_BUSY     = 3'd2,
    ST_GAP      = 3'd3,
    ST_DONE     = 3'd4,
    ST_ERR      = 3'd5
  } cfg_state_t;

  function automatic logic [15:0] pack_reg(input logic [6:0] addr,
                                           input logic [8:0] data);
    return {addr, data};
  endfunction

endpackage

`default_nettype wire

// File: rtl/wm8978_reg_rom.sv
// ============================================================================
// Module : wm8978_reg_rom
// Brief  : Fixed power-up register table, index -> {addr, data}.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wm8978_reg_rom
  import wm8978_pkg::*;
#(
  parameter logic [4:0] REG_NUM = 5'd19
) (
  input  logic [4:0]  idx,
  output logic [15:0] word
);

  localparam logic [6:0] c_r_srate  = 7'd7;
  localparam logic [6:0] c_r_dac    = 7'd10;
  localparam logic [6:0] c_r_adc    = 7'd14;
  localparam logic [6:0] c_r_bias   = 7'd43;
  localparam logic [6:0] c_r_inctl  = 7'd44;
  localparam logic [6:0] c_r_lpga   = 7'd45;
  localparam logic [6:0] c_r_lboost = 7'd47;
  localparam logic [6:0] c_r_rboost = 7'd48;
  localparam logic [6:0] c_r_outctl = 7'd49;
  localparam logic [6:0] c_r_lmix   = 7'd50;
  localparam logic [6:0] c_r_rmix   = 7'd51;

  always_comb begin
    word = 16'h0000;
    if (idx < REG_NUM) begin
      case (idx)
        5'd0:    word = pack_reg(R_RESET,     9'h000);
        5'd1:    word = pack_reg(R_PWR1,      9'h01B);
        5'd2:    word = pack_reg(R_PWR2,      9'h1BF);
        5'd3:    word = pack_reg(R_PWR3,      9'h06F);
        5'd4:    word = pack_reg(R_AIF,       9'h070);  // I2S, 32-bit words
        5'd5:    word = pack_reg(R_CLK,       9'h000);  // slave, MCLK direct
        5'd6:    word = pack_reg(c_r_srate,   9'h000);
        5'd7:    word = pack_reg(c_r_dac,     9'h008);
        5'd8:    word = pack_reg(c_r_adc,     9'h108);
        5'd9:    word = pack_reg(c_r_bias,    9'h010);
        5'd10:   word = pack_reg(c_r_inctl,   9'h000);
        5'd11:   word = pack_reg(c_r_lpga,    9'h140);  // mic PGA muted, line-in only
        5'd12:   word = pack_reg(c_r_lboost,  9'h050);
        5'd13:   word = pack_reg(c_r_rboost,  9'h050);
        5'd14:   word = pack_reg(c_r_outctl,  9'h002);
        5'd15:   word = pack_reg(c_r_lmix,    9'h001);
        5'd16:   word = pack_reg(c_r_rmix,    9'h001);
        5'd17:   word = pack_reg(R_LOUT1,     9'h039);
        5'd18:   word = pack_reg(R_ROUT1,     9'h139);  // HPVU latches both channels
        default: word = 16'h0000;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/wm8978_cfg_seq.sv
// ============================================================================
// Module : wm8978_cfg_seq
// Brief  : WM8978 power-up register sequencer driving an I2C exec/done driver.
//          Optional macro WM8978_VOL_UPDATE_EN adds runtime headphone volume.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wm8978_cfg_seq
  import wm8978_pkg::*;
#(
  parameter logic [19:0] STARTUP_CYCLES = 20'd1_000_000,
  parameter logic [4:0]  REG_NUM        = 5'd19,
  parameter logic [9:0]  GAP_CYCLES     = 10'd500,
  parameter logic [1:0]  MAX_RETRY      = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  output logic        i2c_exec,
  output logic [15:0] i2c_data,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  input  logic        vol_req,
  input  logic [5:0]  vol_val,
  output logic        vol_ack,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam logic [19:0] c_startup_last =
    (STARTUP_CYCLES == 20'd0) ? 20'd0 : STARTUP_CYCLES - 20'd1;
  localparam logic [19:0] c_gap_last =
    (GAP_CYCLES == 10'd0) ? 20'd0 : {10'd0, GAP_CYCLES} - 20'd1;

  cfg_state_t  r_state, w_state_nxt;
  logic [19:0] r_cnt, w_cnt_nxt;
  logic [4:0]  r_idx, w_idx_nxt;
  logic [1:0]  r_retry, w_retry_nxt;
  logic [15:0] r_data, w_data_nxt;
  logic        r_cfg_done, r_cfg_err;
  logic [15:0] w_rom_word, w_issue_word;
  logic        w_vol_mode, w_seq_last, w_xfer_ok;

  wm8978_reg_rom #(
    .REG_NUM (REG_NUM)
  ) u_rom (
    .idx  (r_idx),
    .word (w_rom_word)
  );

  assign w_xfer_ok = (r_state == ST_BUSY) && i2c_done && !i2c_ack_err;

`ifdef WM8978_VOL_UPDATE_EN
  logic       r_vol_mode;
  logic [1:0] r_vol_step;  // 0: R52 pending, 1: R53 pending, 2: both written
  logic [5:0] r_vol;
  logic       r_vol_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vol_mode <= 1'b0;
      r_vol_step <= 2'd0;
      r_vol      <= 6'd0;
      r_vol_ack  <= 1'b0;
    end else begin
      r_vol_ack <= 1'b0;
      if (r_state == ST_DONE && vol_req) begin
        r_vol_mode <= 1'b1;
        r_vol_step <= 2'd0;
        r_vol      <= vol_val;
      end else if (w_xfer_ok && r_vol_mode) begin
        r_vol_step <= r_vol_step + 2'd1;
        r_vol_ack  <= (r_vol_step == 2'd1);
      end else if (r_state == ST_GAP && w_state_nxt == ST_DONE) begin
        r_vol_mode <= 1'b0;
      end
    end
  end

  assign w_vol_mode   = r_vol_mode;
  assign w_issue_word = r_vol_mode
                      ? pack_reg(r_vol_step[0] ? R_ROUT1 : R_LOUT1,
                                 {r_vol_step[0], 2'b00, r_vol})
                      : w_rom_word;
  assign w_seq_last   = r_vol_mode ? (r_vol_step == 2'd2) : (r_idx == REG_NUM);
  assign vol_ack      = r_vol_ack;
`else
  logic w_unused_vol;
  assign w_unused_vol = ^{vol_req, vol_val};
  assign w_vol_mode   = 1'b0;
  assign w_issue_word = w_rom_word;
  assign w_seq_last   = (r_idx == REG_NUM);
  assign vol_ack      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_WAIT_PWR;
      r_cnt      <= 20'd0;
      r_idx      <= 5'd0;
      r_retry    <= 2'd0;
      r_data     <= 16'h0000;
      r_cfg_done <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_retry <= w_retry_nxt;
      r_data  <= w_data_nxt;
      if (w_state_nxt == ST_ERR) begin
        r_cfg_done <= 1'b0;
        r_cfg_err  <= 1'b1;
      end else if (w_state_nxt == ST_DONE) begin
        r_cfg_done <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_retry_nxt = r_retry;
    w_data_nxt  = r_data;
    case (r_state)
      ST_WAIT_PWR: begin
        if (r_cnt >= c_startup_last) begin
          w_state_nxt = ST_ISSUE;
          w_cnt_nxt   = 20'd0;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      ST_ISSUE: begin
        w_data_nxt  = w_issue_word;
        w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (i2c_done) begin
          w_cnt_nxt = 20'd0;
          if (!i2c_ack_err) begin
            if (!w_vol_mode && r_idx < REG_NUM)
              w_idx_nxt = r_idx + 5'd1;
            w_retry_nxt = 2'd0;
            w_state_nxt = ST_GAP;
          end else if (r_retry < MAX_RETRY) begin
            w_retry_nxt = r_retry + 2'd1;
            w_state_nxt = ST_GAP;
          end else begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_GAP: begin
        if (r_cnt >= c_gap_last) begin
          w_cnt_nxt   = 20'd0;
          w_state_nxt = w_seq_last ? ST_DONE : ST_ISSUE;
        end else begin
          w_cnt_nxt = r_cnt + 20'd1;
        end
      end
      ST_DONE: begin
`ifdef WM8978_VOL_UPDATE_EN
        if (vol_req)
          w_state_nxt = ST_ISSUE;
`endif
      end
      ST_ERR: begin
        w_state_nxt = ST_ERR;
      end
      default: begin
        w_state_nxt = ST_WAIT_PWR;
      end
    endcase
  end

  // The word is live during ISSUE so it is valid in the exec cycle itself.
  assign i2c_exec = (r_state == ST_ISSUE);
  assign i2c_data = (r_state == ST_ISSUE) ? w_issue_word : r_data;
  assign cfg_done = r_cfg_done;
  assign cfg_err  = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_wm8978_cfg_seq.sv
// ============================================================================
// Module : tb_wm8978_cfg_seq
// Brief  : Scoreboard bench for wm8978_cfg_seq with an I2C driver model.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wm8978_cfg_seq;

  localparam int T_I2C = 4;

  localparam logic [15:0] TBL [19] = '{
    16'h0000, 16'h021B, 16'h05BF, 16'h066F, 16'h0870, 16'h0C00, 16'h0E00,
    16'h1408, 16'h1D08, 16'h5610, 16'h5800, 16'h5B40, 16'h5E50, 16'h6050,
    16'h6202, 16'h6401, 16'h6601, 16'h6839, 16'h6B39
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2c_exec;
  logic [15:0] i2c_data;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic        vol_req = 1'b0;
  logic [5:0]  vol_val = 6'd0;
  logic        vol_ack;
  logic        cfg_done;
  logic        cfg_err;

  int vectors = 0;
  int miscompares = 0;
  int edge_cnt = 0;
  int exec_cnt = 0;
  int vol_ack_cnt = 0;
  int first_exec_edge = 0;

  logic [15:0] exp_q[$];
  logic [6:0]  nack_addr = 7'h7F;
  int          nack_left = 0;

  wm8978_cfg_seq #(
    .STARTUP_CYCLES (20'd100),
    .REG_NUM        (5'd19),
    .GAP_CYCLES     (10'd10),
    .MAX_RETRY      (2'd3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i2c_exec    (i2c_exec),
    .i2c_data    (i2c_data),
    .i2c_done    (i2c_done),
    .i2c_ack_err (i2c_ack_err),
    .vol_req     (vol_req),
    .vol_val     (vol_val),
    .vol_ack     (vol_ack),
    .cfg_done    (cfg_done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) edge_cnt <= 0;
    else     edge_cnt <= edge_cnt + 1;
  end

  // Driver model: done T_I2C cycles after exec, NACKs by address, plus a
  // spurious NACK-done during the start-up wait and inside every gap.
  int pend = 0;
  int dly = 0;
  int spur_dly = 0;
  always @(negedge clk) begin
    i2c_done    = 1'b0;
    i2c_ack_err = 1'b0;
    if (rst) begin
      pend     = 0;
      spur_dly = 0;
    end else begin
      if (pend != 0) begin
        dly = dly - 1;
        if (dly == 0) begin
          pend     = 0;
          i2c_done = 1'b1;
          spur_dly = 3;
          if (i2c_data[15:9] == nack_addr && nack_left > 0) begin
            i2c_ack_err = 1'b1;
            nack_left   = nack_left - 1;
          end
        end
      end else if (spur_dly > 0) begin
        spur_dly = spur_dly - 1;
        if (spur_dly == 0) begin
          i2c_done    = 1'b1;
          i2c_ack_err = 1'b1;
        end
      end
      if (edge_cnt == 40) begin
        i2c_done    = 1'b1;
        i2c_ack_err = 1'b1;
      end
      if (i2c_exec) begin
        pend = 1;
        dly  = T_I2C;
      end
    end
  end

  // Monitor: pops the scoreboard on every exec pulse.
  logic [15:0] held = 16'h0000;
  logic [15:0] exp_w;
  bit          chk_width = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      held      = 16'h0000;
      chk_width = 1'b0;
    end else begin
      if (chk_width) begin
        chk_width = 1'b0;
        vectors++;
        if (i2c_exec !== 1'b0) begin
          miscompares++;
          $display("FAIL exec_width: exec=%b after pulse, required 0", i2c_exec);
        end
      end else if (i2c_exec) begin
        exec_cnt++;
        chk_width = 1'b1;
        held      = i2c_data;
        if (exec_cnt == 1) first_exec_edge = edge_cnt + 1;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_exec: data=%h, none expected", i2c_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (i2c_data !== exp_w) begin
            miscompares++;
            $display("FAIL exec_data: got %h, required %h", i2c_data, exp_w);
          end
        end
      end
      if (i2c_done && !i2c_exec) begin
        vectors++;
        if (i2c_data !== held) begin
          miscompares++;
          $display("FAIL data_hold: got %h, required %h", i2c_data, held);
        end
      end
      if (vol_ack === 1'b1) vol_ack_cnt++;
    end
  end

  task automatic check(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(TBL[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {i2c_exec, i2c_data, vol_ack, cfg_done, cfg_err}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_end(input string name, input int budget);
    int n;
    n = 0;
    while (!(cfg_done || cfg_err) && n < budget) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= budget) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: no done/err within %0d cycles", name, budget);
    end
  endtask

  int base_exec;
  int base_ack;
  int n;

  initial begin
    // Fault-free table walk with start-up latency check.
    nack_left = 0;
    push_range(0, 18);
    base_exec = exec_cnt;
    do_reset();
    wait_end("clean", 2000);
    repeat (20) @(posedge clk);
    #2;
    check("clean_done", cfg_done, 1);
    check("clean_err", cfg_err, 0);
    check("clean_exec_cnt", exec_cnt - base_exec, 19);
    check("first_exec_edge", first_exec_edge, 101);
    check("clean_queue", exp_q.size(), 0);
    check("clean_vol_ack", vol_ack_cnt, 0);

    // Index 3 NACKed twice, then accepted.
    nack_addr = 7'd3;
    nack_left = 2;
    push_range(0, 3);
    push_range(3, 3);
    push_range(3, 18);
    base_exec = exec_cnt;
    do_reset();
    wait_end("retry", 2500);
    repeat (20) @(posedge clk);
    #2;
    check("retry_done", cfg_done, 1);
    check("retry_err", cfg_err, 0);
    check("retry_exec_cnt", exec_cnt - base_exec, 21);
    check("retry_queue", exp_q.size(), 0);

    // Index 5 (R6) NACKed forever -> error after 1 + MAX_RETRY attempts.
    nack_addr = 7'd6;
    nack_left = 1000;
    push_range(0, 5);
    push_range(5, 5);
    push_range(5, 5);
    push_range(5, 5);
    base_exec = exec_cnt;
    do_reset();
    wait_end("err", 2000);
    repeat (100) @(posedge clk);
    #2;
    check("err_flag", cfg_err, 1);
    check("err_done", cfg_done, 0);
    check("err_exec_cnt", exec_cnt - base_exec, 9);
    check("err_queue", exp_q.size(), 0);

    // Reset asserted while index 7 is in flight.
    nack_addr = 7'h7F;
    nack_left = 0;
    push_range(0, 7);
    base_exec = exec_cnt;
    do_reset();
    n = 0;
    while (exec_cnt - base_exec < 8 && n < 1000) begin
      @(posedge clk);
      #2;
      n++;
    end
    check("abort_reached_idx7", exec_cnt - base_exec, 8);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("abort_outputs", {i2c_exec, i2c_data, vol_ack, cfg_done, cfg_err}, 0);
    check("abort_queue", exp_q.size(), 0);
    push_range(0, 18);
    base_exec = exec_cnt;
    do_reset();
    wait_end("restart", 2000);
    repeat (20) @(posedge clk);
    #2;
    check("restart_done", cfg_done, 1);
    check("restart_exec_cnt", exec_cnt - base_exec, 19);
    check("restart_queue", exp_q.size(), 0);

    // Volume request in DONE.
    base_exec = exec_cnt;
    base_ack  = vol_ack_cnt;
`ifdef WM8978_VOL_UPDATE_EN
    exp_q.push_back(16'h6828);
    exp_q.push_back(16'h6B28);
    vol_val = 6'd40;
    vol_req = 1'b1;
    n = 0;
    while (vol_ack_cnt == base_ack && n < 500) begin
      @(posedge clk);
      #2;
      n++;
    end
    vol_req = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    check("vol_ack_cnt", vol_ack_cnt - base_ack, 1);
    check("vol_exec_cnt", exec_cnt - base_exec, 2);
    check("vol_queue", exp_q.size(), 0);
    check("vol_cfg_done", cfg_done, 1);
`else
    vol_val = 6'd40;
    vol_req = 1'b1;
    repeat (60) @(posedge clk);
    #2;
    vol_req = 1'b0;
    check("vol_ignored_exec", exec_cnt - base_exec, 0);
    check("vol_ignored_ack", vol_ack_cnt - base_ack, 0);
    check("vol_ignored_done", cfg_done, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
